// File: rtl/phy_reset_seq.sv
// phy_reset_seq
//   Sequences the Ethernet PHY hardware reset after system reset or on request,
//   then reports ready. Also synchronizes the asynchronous PHY interrupt line
//   into the clk domain and emits one-cycle event pulses while the PHY is ready.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   reset_req    clk-synchronous request to re-reset the PHY (level)
//   phy_int_n    PHY interrupt, active low, asynchronous to clk
//   phy_reset_n  PHY hardware reset, active low, registered
//   ready        PHY out of reset and settled, registered
//   int_pulse    one-cycle pulse per synchronized falling edge of phy_int_n in READY
//   reset_count  number of accepted reset requests, saturating
//
// State    | meaning
// ---------+-------------------------------------------------------------
// S_ASSERT | phy_reset_n held low for RESET_CYCLES; reset_req ignored
// S_WAIT   | phy_reset_n released, waiting WAIT_CYCLES for the PHY to settle
// S_READY  | PHY usable; interrupt pulses enabled

module phy_reset_seq #(
  parameter int SYNC_N       = 2,
  parameter int RESET_CYCLES = 1250000,
  parameter int WAIT_CYCLES  = 6250000,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_req,
  input  logic                   phy_int_n,
  output logic                   phy_reset_n,
  output logic                   ready,
  output logic                   int_pulse,
  output logic [COUNT_WIDTH-1:0] reset_count
);

  localparam int MAX_CYCLES = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_WAIT   = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic                   r_phy_reset_n;
  logic                   r_ready;
  logic                   r_int_pulse;
  logic [COUNT_WIDTH-1:0] r_reset_count;
  logic [SYNC_N-1:0]      r_sync;
  logic                   r_int_prev;
  logic                   w_int_sync;

  assign w_int_sync = r_sync[SYNC_N-1];

  // Synchronizer resets to 1 so the line looks inactive out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '1;
      r_int_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_N-2:0], phy_int_n};
      r_int_prev <= w_int_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_ASSERT;
      r_timer       <= '0;
      r_phy_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_int_pulse   <= 1'b0;
      r_reset_count <= '0;
    end else begin
      r_int_pulse <= 1'b0;
      case (r_state)
        S_ASSERT: begin
          if (r_timer == RESET_LAST) begin
            r_state       <= S_WAIT;
            r_timer       <= '0;
            r_phy_reset_n <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_WAIT: begin
          // A request beats a simultaneous settle completion.
          if (reset_req) begin
            r_state       <= S_ASSERT;
            r_timer       <= '0;
            r_phy_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            if (r_reset_count != '1) r_reset_count <= r_reset_count + 1'b1;
          end else if (r_timer == WAIT_LAST) begin
            r_state <= S_READY;
            r_timer <= '0;
            r_ready <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_READY: begin
          if (reset_req) begin
            r_state       <= S_ASSERT;
            r_timer       <= '0;
            r_phy_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            if (r_reset_count != '1) r_reset_count <= r_reset_count + 1'b1;
          end else begin
            // Edge detect on the synced line; suppressed on the leaving edge above.
            r_int_pulse <= r_int_prev & ~w_int_sync;
          end
        end

        default: begin
          r_state       <= S_ASSERT;
          r_timer       <= '0;
          r_phy_reset_n <= 1'b0;
          r_ready       <= 1'b0;
        end
      endcase
    end
  end

  assign phy_reset_n = r_phy_reset_n;
  assign ready       = r_ready;
  assign int_pulse   = r_int_pulse;
  assign reset_count = r_reset_count;

endmodule
